alu_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 4-bit ALU (ops add/sub/not/and/or/xor/slt/eq, 3-bit op code) between two requesters. Each requester issues a valid/ready operation request and receives a registered result with carry/zero/overflow flags over a valid/ready response channel. Sits between the two client FSMs and the single ALU instance, and is the only driver of the ALU operand and op inputs.

---
 rtl/alu_share_arb.sv | 138 +++++++++++++
 tb/tb_alu_share_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one external 4-bit ALU between two valid/ready requesters.
// Optional sticky overflow status per requester is enabled by ALU_ARB_STICKY_OVF_EN.
module alu_share_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [3:0] rsp_data,
  output logic [2:0] rsp_flags,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_x,
  input  logic [3:0] alu_out,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  input  logic       ovf_clr,
  output logic       ovf_sticky0,
  output logic       ovf_sticky1
);

  localparam int unsigned DW = 4;
  localparam int unsigned OW = 3;
  localparam int unsigned FW = 3;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] op_q;
  logic [DW-1:0] a_q, b_q;
  logic          gnt_q;
  logic          last_grant;
  logic          grant_c;
  logic          hs_c;
  logic          arith_c;
  logic          rsp_done_c;

  // Single requester wins outright; a tie goes to the one not served last.
  always_comb begin
    grant_c = req1_valid;
    if (req0_valid && req1_valid) grant_c = ~last_grant;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant_c;
  assign req1_ready = (state == IDLE) && req1_valid && grant_c;
  assign hs_c       = req0_ready || req1_ready;
  assign arith_c    = (op_q[2:1] == 2'b00);

  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_x = op_q;

  always_comb begin
    state_nxt  = state;
    rsp_done_c = 1'b0;
    case (state)
      IDLE: if (req0_valid || req1_valid) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_done_c = gnt_q ? rsp1_ready : rsp0_ready;
        if (rsp_done_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, result capture and response valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      gnt_q      <= 1'b0;
      last_grant <= 1'b1;
      rsp_data   <= '0;
      rsp_flags  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      if (hs_c) begin
        op_q  <= grant_c ? req1_op : req0_op;
        a_q   <= grant_c ? req1_a  : req0_a;
        b_q   <= grant_c ? req1_b  : req0_b;
        gnt_q <= grant_c;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_out;
        rsp_flags <= arith_c ? {alu_carry, alu_zero, alu_overflow} : FW'(0);
      end
      if (rsp_done_c) last_grant <= gnt_q;
      rsp0_valid <= (state_nxt == RESP) && !gnt_q;
      rsp1_valid <= (state_nxt == RESP) && gnt_q;
    end
  end

`ifdef ALU_ARB_STICKY_OVF_EN
  logic [1:0] sticky_q;
  logic       set_c;

  assign set_c = (state == EXEC) && arith_c && alu_overflow;

  // A set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q[0] <= (set_c && !gnt_q) || (sticky_q[0] && !ovf_clr);
      sticky_q[1] <= (set_c && gnt_q)  || (sticky_q[1] && !ovf_clr);
    end
  end

  assign ovf_sticky0 = sticky_q[0];
  assign ovf_sticky1 = sticky_q[1];
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky0    = 1'b0;
  assign ovf_sticky1    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU on the shared ALU port.
module tb_alu_share_arb;

`ifdef ALU_ARB_STICKY_OVF_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic       clk, rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [3:0] rsp_data;
  logic [2:0] rsp_flags;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_x;
  logic       alu_carry, alu_zero, alu_overflow;
  logic       ovf_clr, ovf_sticky0, ovf_sticky1;

  int checks = 0;
  int errors = 0;

  alu_share_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_x(alu_x),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow),
    .ovf_clr(ovf_clr), .ovf_sticky0(ovf_sticky0), .ovf_sticky1(ovf_sticky1)
  );

  // External ALU: add, sub, not, and, or, xor, slt (signed), eq.
  logic [4:0] sum;
  always_comb begin
    sum          = 5'd0;
    alu_out      = 4'd0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_x)
      3'd0: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = sum[3:0]; alu_carry = sum[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
      end
      3'd1: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_out = sum[3:0]; alu_carry = sum[4];
        alu_overflow = (alu_a[3] != alu_b[3]) && (sum[3] != alu_a[3]);
      end
      3'd2: alu_out = ~alu_a;
      3'd3: alu_out = alu_a & alu_b;
      3'd4: alu_out = alu_a | alu_b;
      3'd5: alu_out = alu_a ^ alu_b;
      3'd6: alu_out = {3'b000, ($signed(alu_a) < $signed(alu_b))};
      default: alu_out = {3'b000, (alu_a == alu_b)};
    endcase
    alu_zero = (alu_out == 4'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic       id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic [2:0] f;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete transaction from a single requester, checking latency and payload.
  task automatic txn(input vec_t v);
    int n;
    @(negedge clk);
    drive_req(v.id, v.op, v.a, v.b);
    #1;
    n = 0;
    while (!(v.id ? req1_ready : req0_ready) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    check("txn_ready", 32'(v.id ? req1_ready : req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("txn_exec_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    @(negedge clk); #1;
    check("txn_rsp_valid", 32'({rsp1_valid, rsp0_valid}), v.id ? 32'd2 : 32'd1);
    check("txn_rsp_data", 32'(rsp_data), 32'(v.d));
    check("txn_rsp_flags", 32'(rsp_flags), 32'(v.f));
    if (v.id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    check("txn_rsp_done", 32'({rsp1_valid, rsp0_valid}), 32'd0);
  endtask

  vec_t tbl[12];

  initial begin
    int nacc, last, c;
    logic lastid, id, done;

    tbl[0]  = '{1'b0, 3'd0, 4'b0111, 4'b0001, 4'b1000, 3'b001};
    tbl[1]  = '{1'b1, 3'd1, 4'b0011, 4'b0011, 4'b0000, 3'b110};
    tbl[2]  = '{1'b0, 3'd3, 4'b1100, 4'b1010, 4'b1000, 3'b000};
    tbl[3]  = '{1'b1, 3'd4, 4'b1100, 4'b0011, 4'b1111, 3'b000};
    tbl[4]  = '{1'b0, 3'd5, 4'b1010, 4'b0110, 4'b1100, 3'b000};
    tbl[5]  = '{1'b1, 3'd2, 4'b0101, 4'b0000, 4'b1010, 3'b000};
    tbl[6]  = '{1'b1, 3'd6, 4'b1000, 4'b0001, 4'b0001, 3'b000};
    tbl[7]  = '{1'b0, 3'd6, 4'b0001, 4'b1000, 4'b0000, 3'b000};
    tbl[8]  = '{1'b1, 3'd7, 4'b0101, 4'b0101, 4'b0001, 3'b000};
    tbl[9]  = '{1'b0, 3'd0, 4'b1111, 4'b0001, 4'b0000, 3'b110};
    tbl[10] = '{1'b1, 3'd1, 4'b1000, 4'b0001, 4'b0111, 3'b101};
    tbl[11] = '{1'b0, 3'd0, 4'b1000, 4'b1000, 4'b0000, 3'b111};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0; ovf_clr = 1'b0;
    #12;
    check("rst_valids", 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid}), 32'd0);
    check("rst_rsp", 32'({rsp_data, rsp_flags}), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_x}), 32'd0);
    check("rst_sticky", 32'({ovf_sticky0, ovf_sticky1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests straight after reset: req0 wins the first tie.
    @(negedge clk);
    drive_req(1'b0, 3'd3, 4'b1100, 4'b1010);
    drive_req(1'b1, 3'd1, 4'b0011, 4'b0011);
    #1;
    check("sim_grant", 32'({req0_ready, req1_ready}), 32'd2);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("sim_exec_wait", 32'(req1_ready), 32'd0);
    @(negedge clk); #1;
    check("sim_rsp0_valid", 32'({rsp1_valid, rsp0_valid}), 32'd1);
    check("sim_rsp0_data", 32'({rsp_data, rsp_flags}), 32'({4'b1000, 3'b000}));
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    check("sim_req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk); #1;
    check("sim_rsp1_valid", 32'({rsp1_valid, rsp0_valid}), 32'd2);
    check("sim_rsp1_data", 32'({rsp_data, rsp_flags}), 32'({4'b0000, 3'b110}));
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;

    // Table of single-requester transactions across all ops.
    for (int i = 0; i < 12; i++) txn(tbl[i]);
    #1;
    check("tbl_sticky", 32'({ovf_sticky0, ovf_sticky1}), 32'({STK, STK}));

    // Fairness under continuous load with responses always accepted.
    reset_dut();
    drive_req(1'b0, 3'd0, 4'b0001, 4'b0001);
    drive_req(1'b1, 3'd5, 4'b0101, 4'b0011);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    nacc = 0; last = -10; lastid = 1'b0; done = 1'b0;
    for (c = 0; c < 40 && !done; c++) begin
      #1;
      if (nacc > 0 && c == last + 2) begin
        check("fair_rsp_valid", 32'({rsp1_valid, rsp0_valid}), lastid ? 32'd2 : 32'd1);
        check("fair_rsp_data", 32'(rsp_data), lastid ? 32'h6 : 32'h2);
        if (nacc == 6) done = 1'b1;
      end
      if (!done && (req0_ready || req1_ready)) begin
        id = req1_ready;
        check("fair_grant", 32'(id), 32'(nacc % 2));
        if (nacc > 0) check("fair_interval", 32'(c - last), 32'd3);
        last = c; lastid = id; nacc++;
      end
      if (!done) @(negedge clk);
    end
    if (!done) check("fair_timeout", 32'd0, 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Response backpressure on req1 while req0 waits.
    @(negedge clk);
    drive_req(1'b1, 3'd4, 4'b1100, 4'b0011);
    #1;
    check("bp_req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    drive_req(1'b0, 3'd0, 4'b0111, 4'b0001);
    #1;
    check("bp_exec_req0_ready", 32'(req0_ready), 32'd0);
    @(negedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp1_valid", 32'({rsp1_valid, rsp0_valid}), 32'd2);
      check("bp_hold", 32'({rsp_data, rsp_flags}), 32'({4'b1111, 3'b000}));
      check("bp_req0_ready", 32'(req0_ready), 32'd0);
      @(negedge clk); #1;
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1;
    check("bp_resume", 32'({req0_ready, rsp1_valid}), 32'd2);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    check("bp_rsp0", 32'({rsp0_valid, rsp_data, rsp_flags}), 32'({1'b1, 4'b1000, 3'b001}));
    check("bp_sticky", 32'({ovf_sticky0, ovf_sticky1}), 32'({STK, 1'b0}));
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;

    // Sticky clear, then set and clear colliding in the same cycle.
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    #1;
    check("clr_sticky0", 32'(ovf_sticky0), 32'd0);
    @(negedge clk);
    drive_req(1'b0, 3'd0, 4'b0111, 4'b0001);
    #1;
    check("setclr_ready", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    #1;
    check("setclr_sticky0", 32'(ovf_sticky0), 32'(STK));
    check("setclr_rsp0", 32'(rsp0_valid), 32'd1);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;

    // Reset during EXEC drops the operation.
    @(negedge clk);
    drive_req(1'b1, 3'd0, 4'b0111, 4'b0001);
    #1;
    check("rmid_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rmid_valids", 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid}), 32'd0);
    check("rmid_rsp", 32'({rsp_data, rsp_flags}), 32'd0);
    check("rmid_alu", 32'({alu_a, alu_b, alu_x}), 32'd0);
    check("rmid_sticky", 32'({ovf_sticky0, ovf_sticky1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("rmid_no_rsp", 32'({rsp0_valid, rsp1_valid, ovf_sticky1}), 32'd0);
    end
    drive_req(1'b0, 3'd7, 4'b0011, 4'b0011);
    drive_req(1'b1, 3'd7, 4'b0011, 4'b0010);
    #1;
    check("rmid_tie_grant", 32'({req0_ready, req1_ready}), 32'd2);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #1;
    check("rmid_rsp0", 32'({rsp0_valid, rsp_data, rsp_flags}), 32'({1'b1, 4'b0001, 3'b000}));
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
